// File: rtl/pulse_doppler_sequencer.sv
// Pulsed-wave Doppler PRF sequencer: burst -> range-gate delay -> sample window -> hold-off, back-to-back while run is high.
// Outputs decode a registered state; frameDone/overrun/sampleCount land one cycle after pc=P-1; optional macro TX_RX_GUARD_EN.
module pulse_doppler_sequencer #(
  parameter int CNT_W  = 16,
  parameter int SCNT_W = 12,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [1:0]        freqSelIn,
  input  logic [CNT_W-1:0]  prfPeriod,
  input  logic [CNT_W-1:0]  burstLen,
  input  logic [CNT_W-1:0]  gateDelay,
  input  logic [CNT_W-1:0]  gateLen,
  input  logic              rxReady,
  output logic              txGate,
  output logic [1:0]        txFreqSel,
  output logic              txPwdn,
  output logic              rxEnable,
  output logic              busy,
  output logic              frameDone,
  output logic              overrun,
  output logic              cfgErr,
  output logic [SCNT_W-1:0] sampleCount
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

`ifdef TX_RX_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, BURST, DELAY, SAMPLE, HOLDOFF} state_t;

  state_t state, stateNext;
  logic latch, refuse, periodEnd, startOk, lastCycle;
  logic [CNT_W-1:0] pc, perLen, effDelay;
  logic [SUM_W-1:0] endBurst, endDelay, endSample;
  logic [SUM_W-1:0] inEndB, inEndD, inEndS;
  logic [1:0] freqLatch;
  logic ovFlag;
  logic [SCNT_W-1:0] sCnt, sCntNext;

  // Phase boundaries are kept as cumulative end offsets so zero-length phases fall through
  function automatic state_t phaseOf(input logic [SUM_W-1:0] pos, input logic [SUM_W-1:0] eB,
                                     input logic [SUM_W-1:0] eD, input logic [SUM_W-1:0] eS);
    if (pos < eB)      return BURST;
    else if (pos < eD) return DELAY;
    else if (pos < eS) return SAMPLE;
    else               return HOLDOFF;
  endfunction

  assign effDelay  = (GUARD_ON && (gateDelay < GUARD_C)) ? GUARD_C : gateDelay;
  assign inEndB    = SUM_W'(burstLen);
  assign inEndD    = inEndB + SUM_W'(effDelay);
  assign inEndS    = inEndD + SUM_W'(gateLen);
  assign startOk   = run && (prfPeriod != '0);
  assign lastCycle = (pc == perLen - CNT_W'(1));

  always_comb begin
    stateNext = state;
    latch     = 1'b0;
    refuse    = 1'b0;
    periodEnd = 1'b0;
    if (state == IDLE) begin
      if (startOk) begin
        latch     = 1'b1;
        stateNext = phaseOf(SUM_W'(0), inEndB, inEndD, inEndS);
      end else if (run) begin
        refuse = 1'b1;
      end
    end else if (lastCycle) begin
      periodEnd = 1'b1;
      if (startOk) begin
        latch     = 1'b1;
        stateNext = phaseOf(SUM_W'(0), inEndB, inEndD, inEndS);
      end else begin
        stateNext = IDLE;
        refuse    = run;
      end
    end else begin
      stateNext = phaseOf(SUM_W'(pc) + SUM_W'(1), endBurst, endDelay, endSample);
    end
  end

  assign sCntNext = ((state == SAMPLE) && rxReady && (sCnt != '1)) ? sCnt + SCNT_W'(1) : sCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      perLen      <= '0;
      endBurst    <= '0;
      endDelay    <= '0;
      endSample   <= '0;
      freqLatch   <= 2'b11;
      ovFlag      <= 1'b0;
      sCnt        <= '0;
      sampleCount <= '0;
      frameDone   <= 1'b0;
      overrun     <= 1'b0;
      cfgErr      <= 1'b0;
    end else begin
      state     <= stateNext;
      frameDone <= periodEnd;
      overrun   <= periodEnd & ovFlag;
      cfgErr    <= refuse;
      if (periodEnd) sampleCount <= sCntNext;
      if (latch) begin
        perLen    <= prfPeriod;
        endBurst  <= inEndB;
        endDelay  <= inEndD;
        endSample <= inEndS;
        freqLatch <= freqSelIn;
        ovFlag    <= (inEndS > SUM_W'(prfPeriod));
        pc        <= '0;
        sCnt      <= '0;
      end else begin
        sCnt <= sCntNext;
        pc   <= (stateNext == IDLE) ? '0 : pc + CNT_W'(1);
      end
    end
  end

  assign txGate    = (state == BURST);
  assign rxEnable  = (state == SAMPLE);
  assign txPwdn    = (state == IDLE);
  assign busy      = !txPwdn;
  assign txFreqSel = freqLatch;

endmodule

// File: tb/tb_pulse_doppler_sequencer.sv
// Bench for pulse_doppler_sequencer: period-level reference model checked every cycle, plus directed literal checkpoints.
module tb_pulse_doppler_sequencer;

  logic        clk, reset, run, rxReady;
  logic [1:0]  freqSelIn;
  logic [15:0] prfPeriod, burstLen, gateDelay, gateLen;
  logic        txGate, txPwdn, rxEnable, busy, frameDone, overrun, cfgErr;
  logic [1:0]  txFreqSel;
  logic [11:0] sampleCount;

  int checks = 0;
  int errors = 0;

  pulse_doppler_sequencer #(.CNT_W(16), .SCNT_W(12), .GUARD(4)) dut (
    .clk(clk), .reset(reset), .run(run), .freqSelIn(freqSelIn),
    .prfPeriod(prfPeriod), .burstLen(burstLen), .gateDelay(gateDelay), .gateLen(gateLen),
    .rxReady(rxReady), .txGate(txGate), .txFreqSel(txFreqSel), .txPwdn(txPwdn),
    .rxEnable(rxEnable), .busy(busy), .frameDone(frameDone), .overrun(overrun),
    .cfgErr(cfgErr), .sampleCount(sampleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one period described by its latched lengths and a cycle index
  int mActive = 0, mPc = 0, mP = 0, mB = 0, mDe = 0, mG = 0, mCnt = 0, mFreq = 3;
  int eFd = 0, eOv = 0, eCfg = 0, eSc = 0;

  function automatic int effD(input int d);
`ifdef TX_RX_GUARD_EN
    return (d < 4) ? 4 : d;
`else
    return d;
`endif
  endfunction

  function automatic bit inWindow(input int p);
    return mActive != 0 && p >= mB + mDe && p < mB + mDe + mG;
  endfunction

  task automatic modelStep();
    bit endP;
    endP = 0;
    if (reset) begin
      mActive = 0; mPc = 0; mCnt = 0; mFreq = 3;
      eFd = 0; eOv = 0; eCfg = 0; eSc = 0;
      return;
    end
    eFd = 0; eOv = 0; eCfg = 0;
    if (mActive != 0) begin
      if (rxReady && inWindow(mPc)) mCnt = (mCnt < 4095) ? mCnt + 1 : 4095;
      if (mPc == mP - 1) begin
        endP = 1; eFd = 1; eOv = (mB + mDe + mG > mP) ? 1 : 0; eSc = mCnt;
      end else begin
        mPc++;
      end
    end
    if (mActive == 0 || endP) begin
      if (run && prfPeriod != 0) begin
        mActive = 1; mPc = 0; mCnt = 0;
        mP = prfPeriod; mB = burstLen; mDe = effD(int'(gateDelay)); mG = gateLen;
        mFreq = freqSelIn;
      end else begin
        mActive = 0; mPc = 0;
        if (run) eCfg = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      modelStep();
      chk("txGate",      txGate,      (mActive != 0 && mPc < mB));
      chk("rxEnable",    rxEnable,    inWindow(mPc));
      chk("txPwdn",      txPwdn,      (mActive == 0));
      chk("busy",        busy,        (mActive != 0));
      chk("txFreqSel",   txFreqSel,   mFreq);
      chk("frameDone",   frameDone,   eFd);
      chk("overrun",     overrun,     eOv);
      chk("cfgErr",      cfgErr,      eCfg);
      chk("sampleCount", sampleCount, eSc);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

`ifdef TX_RX_GUARD_EN
  localparam logic [19:0] RX1 = 20'h01F00;
  localparam logic [9:0]  RX2 = 10'h300;
  localparam logic        SAT_OV = 1'b1;
`else
  localparam logic [19:0] RX1 = 20'h00F80;
  localparam logic [9:0]  RX2 = 10'h380;
  localparam logic        SAT_OV = 1'b0;
`endif

  logic [19:0] txTrace, rxTrace;
  logic [9:0]  rx2Trace;

  initial begin
    reset = 1'b1; run = 1'b0; rxReady = 1'b0; freqSelIn = 2'b01;
    prfPeriod = 16'd20; burstLen = 16'd4; gateDelay = 16'd3; gateLen = 16'd5;
    txTrace = '0; rxTrace = '0; rx2Trace = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_txPwdn", txPwdn, 1);
    chk("rst_freq", txFreqSel, 2'b11);
    chk("rst_busy", busy, 0);

    // P=20 B=4 D=3 G=5 with rxReady 3x inside the window, 2x outside
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      txTrace[k] = txGate;
      rxTrace[k] = rxEnable;
      rxReady = (k == 3 || k == 8 || k == 10 || k == 11 || k == 15);
    end
    tick();
    rxReady = 1'b0;
    chk("p1_txTrace", txTrace, 20'h0000F);
    chk("p1_rxTrace", rxTrace, RX1);
    chk("p1_frameDone", frameDone, 1);
    chk("p1_sampleCount", sampleCount, 3);
    chk("p1_overrun", overrun, 0);
    chk("p1_freq", txFreqSel, 2'b01);

    // Truncated period: P=10 G=6, re-latched at the next period boundary
    prfPeriod = 16'd10; gateLen = 16'd6;
    repeat (19) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      rx2Trace[k] = rxEnable;
      if (k == 0) chk("p2_frameDone", frameDone, 1);
    end
    chk("p3_rxTrace", rx2Trace, RX2);

    // P=0 at re-latch: drop to IDLE and keep refusing
    prfPeriod = 16'd0;
    tick();
    chk("p3_frameDone", frameDone, 1);
    chk("p3_overrun", overrun, 1);
    chk("cfgErr_first", cfgErr, 1);
    chk("cfgErr_busy", busy, 0);
    tick();
    chk("cfgErr_repeat", cfgErr, 1);
    chk("cfgErr_txGate", txGate, 0);
    chk("cfgErr_noFrame", frameDone, 0);
    prfPeriod = 16'd8;
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_cfgErr", cfgErr, 0);

    // Graceful stop: run dropped at pc=5 of a P=20 period
    prfPeriod = 16'd20; gateLen = 16'd5; rxReady = 1'b1;
    repeat (7) tick();
    tick();
    repeat (5) tick();
    run = 1'b0;
    repeat (14) tick();
    tick();
    chk("stop_frameDone", frameDone, 1);
    chk("stop_busy", busy, 0);
    chk("stop_txPwdn", txPwdn, 1);
    chk("stop_sampleCount", sampleCount, 5);
    rxReady = 1'b0;
    tick();
    chk("stop_frameDone_clr", frameDone, 0);

    // Reset at pc=2 of BURST
    run = 1'b1;
    repeat (3) tick();
    chk("pre_rst_txGate", txGate, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_txGate", txGate, 0);
    chk("mid_rst_txPwdn", txPwdn, 1);
    chk("mid_rst_freq", txFreqSel, 2'b11);
    chk("mid_rst_sampleCount", sampleCount, 0);
    reset = 1'b0; run = 1'b0;
    tick();

    // Sample counter saturation
    prfPeriod = 16'd4200; burstLen = 16'd0; gateDelay = 16'd0; gateLen = 16'd4200;
    rxReady = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    repeat (4199) tick();
    tick();
    chk("sat_frameDone", frameDone, 1);
    chk("sat_sampleCount", sampleCount, 12'hFFF);
    chk("sat_overrun", overrun, SAT_OV);
    rxReady = 1'b0;

    // Randomized run against the model
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        prfPeriod = 16'($urandom_range(0, 24));
        burstLen  = 16'($urandom_range(0, 8));
        gateDelay = 16'($urandom_range(0, 8));
        gateLen   = 16'($urandom_range(0, 10));
        freqSelIn = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 29) == 0) run = ~run;
      rxReady = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
